// File: rtl/mux_src_bank8x4.sv
// mux_src_bank8x4: source stage for the 8-to-1 x WIDTH output mux.
// Eight writable WIDTH-bit registers feed the mux data inputs. A small
// sequencer produces the registered 3-bit mux select. It supports four modes:
// hold, step on a rising edge of `step`, timed auto-scan, and direct load.
// Every output comes straight from a flop, so it can be wired to the
// combinational mux without adding a timing path.

module mux_src_bank8x4 #(
    parameter int WIDTH = 4,   // data width of each bank register
    parameter int DWELL = 4    // cycles per select value in AUTO mode, 1..16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic [2:0]       sel_load,
    output logic [WIDTH-1:0] q_0,
    output logic [WIDTH-1:0] q_1,
    output logic [WIDTH-1:0] q_2,
    output logic [WIDTH-1:0] q_3,
    output logic [WIDTH-1:0] q_4,
    output logic [WIDTH-1:0] q_5,
    output logic [WIDTH-1:0] q_6,
    output logic [WIDTH-1:0] q_7,
    output logic [2:0]       select,
    output logic             wrap
);

    // Sequencer modes, encoded as they appear on the `mode` pins.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_STEP = 2'b01,
        MODE_AUTO = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // A 4-bit counter covers the largest legal dwell (counts 0..15).
    localparam int                CNT_W      = 4;
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] bank_q [8];
    logic [WIDTH-1:0] bank_d [8];

    logic [2:0]       sel_q,   sel_d;
    logic             wrap_q,  wrap_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             step_hist_q;   // `step` as sampled on the previous edge

    mode_e            cur_mode;
    logic             step_edge;
    logic             advance;       // select moves forward by one on this edge

    assign cur_mode  = mode_e'(mode);
    assign step_edge = step & ~step_hist_q;

    // ------------------------------------------------------------------
    // Register bank: single write port, and the other registers hold.
    // ------------------------------------------------------------------
    // Next-state for the bank: copy, then overlay the addressed write.
    always_comb begin
        // NOTE: every combinational output gets a full default first, so
        // no path can leave it unassigned and infer a latch.
        bank_d = bank_q;
        if (wr_en) begin
            bank_d[wr_addr] = wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // Next select, dwell count and wrap pulse from the current mode.
    always_comb begin
        sel_d   = sel_q;
        dwell_d = '0;      // any mode other than AUTO discards a partial dwell
        advance = 1'b0;

        unique case (cur_mode)
            MODE_HOLD: begin
                sel_d = sel_q;
            end
            MODE_STEP: begin
                advance = step_edge;
            end
            MODE_AUTO: begin
                if (dwell_q == DWELL_LAST) begin
                    advance = 1'b1;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end
            MODE_LOAD: begin
                sel_d = sel_load;
            end
            default: begin
                sel_d = sel_q;
            end
        endcase

        if (advance) begin
            sel_d = sel_q + 3'd1;
        end

        // Only a counting increment out of 7 wraps. A load never wraps.
        wrap_d = advance && (sel_q == 3'd7);
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    // All state updates on the rising edge, and reset overrides every input.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values no matter what order the statements are in.
        if (reset) begin
            // NOTE: the bank is a handful of flops with defined power-up
            // contents (q_k = k), not a RAM macro, so it is reset like any
            // other register.
            for (int k = 0; k < 8; k++) begin
                bank_q[k] <= WIDTH'(k);
            end
            sel_q       <= 3'd0;
            wrap_q      <= 1'b0;
            dwell_q     <= '0;
            step_hist_q <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            sel_q       <= sel_d;
            wrap_q      <= wrap_d;
            dwell_q     <= dwell_d;
            step_hist_q <= step;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: straight from flops
    // ------------------------------------------------------------------
    assign q_0    = bank_q[0];
    assign q_1    = bank_q[1];
    assign q_2    = bank_q[2];
    assign q_3    = bank_q[3];
    assign q_4    = bank_q[4];
    assign q_5    = bank_q[5];
    assign q_6    = bank_q[6];
    assign q_7    = bank_q[7];
    assign select = sel_q;
    assign wrap   = wrap_q;

endmodule
